// File: rtl/hp_sweep_ctrl.sv
// Wishbone-programmed glitch-offset sweep sequencer for the hoggephase detector pair.
// Optional stop-on-first-hit support is compiled in with `define HP_SWEEP_STOP_ON_HIT_EN.
module hp_sweep_ctrl #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0100,
    parameter int          OFFSET_W       = 20,
    parameter int          SETTLE_CYCLES  = 16,
    parameter int          OBSERVE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        hp_Alarm_latch_async_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    input  logic        hp_alarm_latch,
    input  logic [7:0]  hp_alarm_ctr,
    output logic        hp_vcc,
    output logic        hp_alarm_rst,
    output logic        hp_alarm_ctr_rst,
    output logic        hp_glitch_fire,
    output logic        busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RST_DET = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_DELAY   = 3'd3;
    localparam logic [2:0] S_FIRE    = 3'd4;
    localparam logic [2:0] S_OBSERVE = 3'd5;
    localparam logic [2:0] S_RECORD  = 3'd6;
    localparam logic [2:0] S_STEP    = 3'd7;

    // Phase counter must hold both the longest fixed phase and any offset.
    localparam int CNT_W = (OFFSET_W > 16) ? OFFSET_W : 16;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nxt;
    logic [OFFSET_W-1:0] cur_off_q, cur_off_d;
    logic [OFFSET_W-1:0] start_off_q, start_off_d;
    logic [OFFSET_W-1:0] stop_off_q, stop_off_d;
    logic [OFFSET_W-1:0] step_q, step_d;
    logic [OFFSET_W-1:0] first_hit_q, first_hit_d;
    logic [15:0]         hits_q, hits_d;
    logic [7:0]          last_ctr_q, last_ctr_d;
    logic                done_q, done_d;
    logic                hit_seen_q, hit_seen_d;
    logic                ack_q;
    logic [31:0]         rdata_q, rd_data;

    logic                wb_acc, wb_wr, cfg_wr, ctrl_wr, start_req, abort_req;
    logic [2:0]          reg_sel;
    logic [OFFSET_W-1:0] eff_step;
    logic [OFFSET_W:0]   step_sum;
    logic                stop_on_hit;
    logic                unused_bits;

    assign wb_acc    = i_wb_cyc && i_wb_stb && (i_wb_addr[31:5] == BASE_ADDRESS[31:5]);
    assign wb_wr     = wb_acc && i_wb_we;
    assign reg_sel   = i_wb_addr[4:2];
    assign cfg_wr    = wb_wr && (state_q == S_IDLE);
    assign ctrl_wr   = wb_wr && (reg_sel == 3'd0);
    assign start_req = ctrl_wr && i_wb_data[0];
    assign abort_req = ctrl_wr && i_wb_data[1];
    assign unused_bits = ^{i_wb_addr[1:0], i_wb_data};

    assign cnt_nxt  = cnt_q + CNT_W'(1);
    assign eff_step = (step_q == '0) ? OFFSET_W'(1) : step_q;
    // The extra top bit catches wrap-around past the last representable offset.
    assign step_sum = {1'b0, cur_off_q} + {1'b0, eff_step};

`ifdef HP_SWEEP_STOP_ON_HIT_EN
    logic soh_q, soh_d;

    always_comb begin
        soh_d = soh_q;
        if (cfg_wr && reg_sel == 3'd0) soh_d = i_wb_data[2];
    end

    always_ff @(posedge clk or posedge hp_Alarm_latch_async_rst) begin
        if (hp_Alarm_latch_async_rst) soh_q <= 1'b0;
        else                          soh_q <= soh_d;
    end

    assign stop_on_hit = soh_q;
`else
    assign stop_on_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_nxt;
        cur_off_d   = cur_off_q;
        start_off_d = start_off_q;
        stop_off_d  = stop_off_q;
        step_d      = step_q;
        first_hit_d = first_hit_q;
        hits_d      = hits_q;
        last_ctr_d  = last_ctr_q;
        done_d      = done_q;
        hit_seen_d  = hit_seen_q;

        if (cfg_wr) begin
            case (reg_sel)
                3'd1:    start_off_d = i_wb_data[OFFSET_W-1:0];
                3'd2:    stop_off_d  = i_wb_data[OFFSET_W-1:0];
                3'd3:    step_d      = i_wb_data[OFFSET_W-1:0];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_req && !abort_req) begin
                    state_d    = S_RST_DET;
                    cnt_d      = '0;
                    cur_off_d  = start_off_q;
                    hits_d     = '0;
                    hit_seen_d = 1'b0;
                    done_d     = 1'b0;
                end
            end
            S_RST_DET: begin
                if (cnt_nxt == CNT_W'(2)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_nxt == CNT_W'(SETTLE_CYCLES)) begin
                    state_d = (cur_off_q == '0) ? S_FIRE : S_DELAY;
                    cnt_d   = '0;
                end
            end
            S_DELAY: begin
                if (cnt_nxt == CNT_W'(cur_off_q)) begin
                    state_d = S_FIRE;
                    cnt_d   = '0;
                end
            end
            S_FIRE: begin
                state_d = S_OBSERVE;
                cnt_d   = '0;
            end
            S_OBSERVE: begin
                if (cnt_nxt == CNT_W'(OBSERVE_CYCLES)) begin
                    state_d = S_RECORD;
                    cnt_d   = '0;
                end
            end
            S_RECORD: begin
                last_ctr_d = hp_alarm_ctr;
                state_d    = S_STEP;
                if (hp_alarm_latch) begin
                    hits_d = (hits_q == 16'hFFFF) ? hits_q : hits_q + 16'd1;
                    if (!hit_seen_q) begin
                        first_hit_d = cur_off_q;
                        hit_seen_d  = 1'b1;
                    end
                    if (stop_on_hit) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (step_sum[OFFSET_W] || (step_sum[OFFSET_W-1:0] > stop_off_q)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cur_off_d = step_sum[OFFSET_W-1:0];
                    state_d   = S_RST_DET;
                    cnt_d     = '0;
                end
            end
        endcase

        // Abort leaves results untouched and never reports completion.
        if (abort_req && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = done_q;
        end
    end

    always_ff @(posedge clk or posedge hp_Alarm_latch_async_rst) begin
        if (hp_Alarm_latch_async_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cur_off_q   <= '0;
            start_off_q <= '0;
            stop_off_q  <= '0;
            step_q      <= OFFSET_W'(1);
            first_hit_q <= '0;
            hits_q      <= '0;
            last_ctr_q  <= '0;
            done_q      <= 1'b0;
            hit_seen_q  <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_off_q   <= cur_off_d;
            start_off_q <= start_off_d;
            stop_off_q  <= stop_off_d;
            step_q      <= step_d;
            first_hit_q <= first_hit_d;
            hits_q      <= hits_d;
            last_ctr_q  <= last_ctr_d;
            done_q      <= done_d;
            hit_seen_q  <= hit_seen_d;
            ack_q       <= wb_acc;
            rdata_q     <= (wb_acc && !i_wb_we) ? rd_data : 32'd0;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (reg_sel)
            3'd0:    rd_data = {29'd0, stop_on_hit, 2'b00};
            3'd1:    rd_data = 32'(start_off_q);
            3'd2:    rd_data = 32'(stop_off_q);
            3'd3:    rd_data = 32'(step_q);
            3'd4:    rd_data = {26'd0, hit_seen_q, done_q, busy, state_q};
            3'd5:    rd_data = {16'd0, hits_q};
            3'd6:    rd_data = 32'(first_hit_q);
            default: rd_data = {24'd0, last_ctr_q};
        endcase
    end

    assign o_wb_ack         = ack_q;
    assign o_wb_stall       = 1'b0;
    assign o_wb_data        = rdata_q;
    assign busy             = (state_q != S_IDLE);
    assign hp_alarm_rst     = (state_q == S_RST_DET);
    assign hp_alarm_ctr_rst = (state_q == S_RST_DET);
    assign hp_glitch_fire   = (state_q == S_FIRE);
    assign hp_vcc           = (state_q == S_SETTLE) || (state_q == S_DELAY) || (state_q == S_FIRE) ||
                              (state_q == S_OBSERVE) || (state_q == S_RECORD);

endmodule

// File: tb/tb_hp_sweep_ctrl.sv
// Self-checking bench for hp_sweep_ctrl: trial offsets are recovered from fire timing and
// compared with a list-based sweep model; register results are read back over wishbone.
module tb_hp_sweep_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam int W   = 10;
    localparam int SET = 16;
    localparam int OBS = 64;
    localparam int R_CTRL = 0, R_START = 4, R_STOP = 8, R_STEP = 12;
    localparam int R_STATUS = 16, R_HITS = 20, R_FIRST = 24, R_LAST = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdat = 32'd0;
    logic        ack, stall;
    logic [31:0] rdat;
    logic        latch = 1'b0;
    logic [7:0]  ctr = 8'd0;
    logic        vcc, arst, crst, fire, busy;

    always #5 clk = ~clk;

    hp_sweep_ctrl #(
        .BASE_ADDRESS(BASE), .OFFSET_W(W), .SETTLE_CYCLES(SET), .OBSERVE_CYCLES(OBS)
    ) dut (
        .clk(clk), .hp_Alarm_latch_async_rst(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdat),
        .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdat),
        .hp_alarm_latch(latch), .hp_alarm_ctr(ctr),
        .hp_vcc(vcc), .hp_alarm_rst(arst), .hp_alarm_ctr_rst(crst),
        .hp_glitch_fire(fire), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int hit_offs[$];
    int obs_offs[$];
    int exp_offs[$];
    int width_err, timed_out, last_ctr_drv;
    int exp_hits, exp_seen, exp_first;
    int mdl_first = 0;
    int mdl_last_ctr = 0;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, output logic ok);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdat = d;
        @(negedge clk);
        ok = ack;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output logic ok);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        ok = ack; d = rdat;
        cyc = 1'b0; stb = 1'b0;
    endtask

    function automatic int is_hit(input int o);
        foreach (hit_offs[i]) if (hit_offs[i] == o) return 1;
        return 0;
    endfunction

    // Reference: list of offsets a sweep visits, plus its hit statistics.
    task automatic model_sweep(input int s, input int stop, input int st, input int soh);
        int o, n;
        exp_offs.delete();
        exp_hits = 0; exp_seen = 0; exp_first = mdl_first;
        o = s;
        for (int g = 0; g < 5000; g++) begin
            exp_offs.push_back(o);
            if (is_hit(o) != 0) begin
                exp_hits++;
                if (exp_seen == 0) begin exp_seen = 1; exp_first = o; end
                if (soh != 0) break;
            end
            n = o + ((st == 0) ? 1 : st);
            if (n > stop || n > (1 << W) - 1) break;
            o = n;
        end
    endtask

    // Starts a sweep and watches the detector controls cycle by cycle.
    task automatic run_sweep(input logic [31:0] ctrl_val, input int stop_after_fire);
        int prev, rst_start, rst_len, off, finished;
        obs_offs.delete();
        width_err = 0; timed_out = 0;
        prev = 0; rst_start = 0; rst_len = 0; finished = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = BASE + R_CTRL; wdat = ctrl_val;
        for (int k = 0; k < 30000 && finished == 0; k++) begin
            @(negedge clk);
            if (k == 0) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
            if (crst !== arst) width_err++;
            if (arst === 1'b1) begin
                if (prev == 0) begin rst_start = k; rst_len = 0; latch = 1'b0; end
                rst_len++;
            end else if (prev != 0 && rst_len != 2) begin
                width_err++;
            end
            prev = (arst === 1'b1) ? 1 : 0;
            if (fire === 1'b1) begin
                off = k - rst_start - 2 - SET;
                obs_offs.push_back(off);
                if (stop_after_fire != 0) begin
                    finished = 1;
                end else begin
                    latch = (is_hit(off) != 0);
                    ctr = 8'($urandom_range(0, 255));
                    last_ctr_drv = int'(ctr);
                end
            end
            if (busy === 1'b0) finished = 1;
        end
        if (finished == 0) timed_out = 1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic ok;
        int exp_rst[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        #1;
        n_cmp++;
        if ({ack, vcc, arst, crst, fire, busy, rdat} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got vcc=%b rst=%b fire=%b busy=%b want all 0", vcc, arst, fire, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wb_read(BASE + 32'(i * 4), d, ok);
            n_cmp++;
            if (ok !== 1'b1 || d !== 32'(exp_rst[i])) begin
                n_bad++; $display("FAIL reset_reg%0d: got %h ack=%b want %h", i, d, ok, exp_rst[i]);
            end
        end
    endtask

    task automatic test_wishbone();
        logic [31:0] d;
        logic ok;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0 || rdat !== 32'd0 || ack !== 1'b0) begin
            n_bad++; $display("FAIL wb_idle: got stall=%b data=%h ack=%b want 0/0/0", stall, rdat, ack);
        end
        wb_read(BASE + 32'h20, d, ok);
        n_cmp++;
        if (ok !== 1'b0) begin n_bad++; $display("FAIL wb_oow_read_ack: got %b want 0", ok); end
        wb_write(BASE + 32'h24, 32'h55, ok);
        n_cmp++;
        if (ok !== 1'b0) begin n_bad++; $display("FAIL wb_oow_write_ack: got %b want 0", ok); end
        wb_read(BASE + R_START, d, ok);
        n_cmp++;
        if (d !== 32'd0) begin n_bad++; $display("FAIL wb_oow_no_effect: START got %h want 0", d); end
        wb_write(BASE + R_START, 32'h123, ok);
        wb_read(BASE + R_START, d, ok);
        n_cmp++;
        if (d !== 32'h123 || ok !== 1'b1) begin n_bad++; $display("FAIL wb_start_rw: got %h want 123", d); end
        wb_write(BASE + R_CTRL, 32'h3, ok);
        n_cmp++;
        if (busy !== 1'b0 || ok !== 1'b1) begin
            n_bad++; $display("FAIL abort_start_idle: busy got %b want 0 (ack %b)", busy, ok);
        end
    endtask

    task automatic test_sweep(input int s, input int stop, input int st, input int soh);
        logic [31:0] d;
        logic ok;
        int eff_soh, bad;
`ifdef HP_SWEEP_STOP_ON_HIT_EN
        eff_soh = soh;
`else
        eff_soh = 0;
`endif
        wb_write(BASE + R_START, 32'(s), ok);
        wb_write(BASE + R_STOP, 32'(stop), ok);
        wb_write(BASE + R_STEP, 32'(st), ok);
        model_sweep(s, stop, st, eff_soh);
        run_sweep(32'(1 | (soh << 2)), 0);
        n_cmp++;
        if (timed_out != 0) begin n_bad++; $display("FAIL sweep_end s=%0d: busy never dropped", s); end
        n_cmp++;
        if (width_err != 0) begin n_bad++; $display("FAIL rst_pulse s=%0d: %0d bad pulses want 0", s, width_err); end
        bad = (obs_offs.size() != exp_offs.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_offs[i]) if (obs_offs[i] != exp_offs[i]) bad = 1;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL trial_offsets s=%0d stop=%0d step=%0d: got %0d trials first %0d last %0d, want %0d trials first %0d last %0d",
                     s, stop, st, obs_offs.size(), (obs_offs.size() > 0) ? obs_offs[0] : -1,
                     (obs_offs.size() > 0) ? obs_offs[$] : -1, exp_offs.size(), exp_offs[0], exp_offs[$]);
        end
        wb_read(BASE + R_STATUS, d, ok);
        n_cmp++;
        if (d !== 32'((exp_seen << 5) | 16)) begin
            n_bad++; $display("FAIL status s=%0d: got %h want %h", s, d, (exp_seen << 5) | 16);
        end
        wb_read(BASE + R_HITS, d, ok);
        n_cmp++;
        if (d !== 32'(exp_hits)) begin n_bad++; $display("FAIL hits s=%0d: got %0d want %0d", s, d, exp_hits); end
        wb_read(BASE + R_FIRST, d, ok);
        n_cmp++;
        if (d !== 32'(exp_first)) begin n_bad++; $display("FAIL first_hit s=%0d: got %0d want %0d", s, d, exp_first); end
        wb_read(BASE + R_LAST, d, ok);
        n_cmp++;
        if (d !== 32'(last_ctr_drv)) begin n_bad++; $display("FAIL last_ctr s=%0d: got %0d want %0d", s, d, last_ctr_drv); end
        mdl_first = exp_first;
        mdl_last_ctr = last_ctr_drv;
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic ok;
        int fires;
        hit_offs.delete();
        wb_write(BASE + R_START, 32'd3, ok);
        wb_write(BASE + R_STOP, 32'd3, ok);
        wb_write(BASE + R_STEP, 32'd1, ok);
        run_sweep(32'h1, 1);
        n_cmp++;
        if (obs_offs.size() != 1 || timed_out != 0) begin
            n_bad++; $display("FAIL abort_setup: got %0d fires want 1", obs_offs.size());
        end
        wb_write(BASE + R_START, 32'd7, ok);
        wb_write(BASE + R_CTRL, 32'h1, ok);
        wb_read(BASE + R_STATUS, d, ok);
        n_cmp++;
        if (d !== 32'h0D) begin n_bad++; $display("FAIL busy_status_observe: got %h want 0d", d); end
        wb_write(BASE + R_CTRL, 32'h3, ok);
        n_cmp++;
        if (busy !== 1'b0 || vcc !== 1'b0 || ok !== 1'b1) begin
            n_bad++; $display("FAIL abort_edge: busy=%b vcc=%b want 0/0", busy, vcc);
        end
        fires = 0;
        repeat (150) begin @(negedge clk); if (fire !== 1'b0 || busy !== 1'b0) fires++; end
        n_cmp++;
        if (fires != 0) begin n_bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", fires); end
        wb_read(BASE + R_STATUS, d, ok);
        n_cmp++;
        if (d !== 32'd0) begin n_bad++; $display("FAIL abort_status: got %h want 0", d); end
        wb_read(BASE + R_START, d, ok);
        n_cmp++;
        if (d !== 32'd3) begin n_bad++; $display("FAIL cfg_write_busy: START got %0d want 3", d); end
        wb_read(BASE + R_FIRST, d, ok);
        n_cmp++;
        if (d !== 32'(mdl_first)) begin n_bad++; $display("FAIL abort_first_kept: got %0d want %0d", d, mdl_first); end
        wb_read(BASE + R_LAST, d, ok);
        n_cmp++;
        if (d !== 32'(mdl_last_ctr)) begin n_bad++; $display("FAIL abort_ctr_kept: got %0d want %0d", d, mdl_last_ctr); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic ok;
        int fires;
        int exp_rst[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        wb_write(BASE + R_START, 32'd50, ok);
        wb_write(BASE + R_STOP, 32'd60, ok);
        wb_write(BASE + R_CTRL, 32'h1, ok);
        repeat (30) @(negedge clk);
        n_cmp++;
        if (vcc !== 1'b1 || busy !== 1'b1 || fire !== 1'b0) begin
            n_bad++; $display("FAIL delay_phase: vcc=%b busy=%b fire=%b want 1/1/0", vcc, busy, fire);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({vcc, arst, crst, fire, busy, ack} !== 6'd0) begin
            n_bad++; $display("FAIL async_rst_outputs: vcc=%b busy=%b want 0", vcc, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        fires = 0;
        repeat (120) begin @(negedge clk); if (fire !== 1'b0 || busy !== 1'b0) fires++; end
        n_cmp++;
        if (fires != 0) begin n_bad++; $display("FAIL async_rst_quiet: got %0d active cycles want 0", fires); end
        for (int i = 0; i < 8; i++) begin
            wb_read(BASE + 32'(i * 4), d, ok);
            n_cmp++;
            if (d !== 32'(exp_rst[i])) begin
                n_bad++; $display("FAIL async_rst_reg%0d: got %h want %h", i, d, exp_rst[i]);
            end
        end
        mdl_first = 0;
        mdl_last_ctr = 0;
    endtask

    task automatic test_ctrl_bit2();
        logic [31:0] d;
        logic ok;
        int exp_ctrl;
`ifdef HP_SWEEP_STOP_ON_HIT_EN
        exp_ctrl = 4;
`else
        exp_ctrl = 0;
`endif
        wb_write(BASE + R_CTRL, 32'h4, ok);
        wb_read(BASE + R_CTRL, d, ok);
        n_cmp++;
        if (d !== 32'(exp_ctrl)) begin n_bad++; $display("FAIL ctrl_bit2: got %h want %h", d, exp_ctrl); end
    endtask

    task automatic test_random();
        int s, stop, st;
        for (int it = 0; it < 4; it++) begin
            hit_offs.delete();
            hit_offs.push_back($urandom_range(0, 25));
            if ($urandom_range(0, 1) == 1) hit_offs.push_back($urandom_range(0, 25));
            s = $urandom_range(0, 15);
            stop = $urandom_range(0, 25);
            st = $urandom_range(0, 4);
            test_sweep(s, stop, st, $urandom_range(0, 1));
        end
    endtask

    initial begin
        test_reset();
        test_wishbone();
        hit_offs.delete();
        test_sweep(5, 5, 1, 0);
        hit_offs.push_back(6);
        test_sweep(0, 9, 3, 0);
        hit_offs.delete();
        test_sweep(2, 4, 0, 0);
        test_sweep(10, 3, 1, 0);
        test_sweep(10'h3FE, 10'h3FF, 4, 0);
        test_abort();
        test_async_reset();
        test_ctrl_bit2();
        hit_offs.delete();
        hit_offs.push_back(4);
        test_sweep(0, 8, 1, 1);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
